// File: rtl/if_stage.sv
// ==================================================================
// if_stage - credit-limited instruction fetch feeding the IF/ID register
// Revision 1.0
// ==================================================================
`default_nettype none
`timescale 1ns/1ps

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_id,
  output logic [31:0] pc_out,
  output logic [31:0] inst_id,
  output logic        inst_valid_id
);

  localparam int              CW         = $clog2(DEPTH + 1);
  localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   c_last_ptr = PW'(DEPTH - 1);
  localparam logic [CW:0]     c_depth    = (CW + 1)'(DEPTH);
  localparam logic [31:0]     c_nop      = 32'h0000_0013;

  logic          r_run;
  logic [31:0]   r_fpc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_pcq [DEPTH];
  logic [PW-1:0] r_pcq_wr, r_pcq_rd;
  logic [31:0]   r_fb_pc   [DEPTH];
  logic [31:0]   r_fb_inst [DEPTH];
  logic [PW-1:0] r_fb_wr, r_fb_rd;
  logic [CW-1:0] r_fb_cnt;
  logic [31:0]   r_pc_out;
  logic [31:0]   r_inst;
  logic          r_inst_valid;

  logic          w_req_hs;
  logic          w_rsp_live;
  logic          w_load_ok;
  logic          w_fb_pop;
  logic [CW:0]   w_used;
  logic [31:0]   w_redirect_target;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == c_last_ptr) ? '0 : p + PW'(1);
  endfunction

  assign w_redirect_target = redirect_pc & ~32'h0000_0003;
  assign w_req_hs          = imem_req_valid && imem_req_ready;
  // Responses still owed to a flushed stream are swallowed here.
  assign w_rsp_live        = imem_rsp_valid && !redirect_valid && (r_drop == '0);
  assign w_load_ok         = !stall_id || !r_inst_valid;
  assign w_fb_pop          = !redirect_valid && w_load_ok && (r_fb_cnt != '0);
  // A buffer entry leaving this cycle frees its credit for a same-cycle request.
  assign w_used            = {1'b0, r_out} + {1'b0, r_fb_cnt} - {{CW{1'b0}}, w_fb_pop};

  assign imem_req_valid = r_run && !redirect_valid && (w_used < c_depth);
  assign imem_req_addr  = r_fpc;
  assign pc_out         = r_pc_out;
  assign inst_id        = r_inst;
  assign inst_valid_id  = r_inst_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run        <= 1'b0;
      r_fpc        <= RESET_PC;
      r_out        <= '0;
      r_drop       <= '0;
      r_pcq_wr     <= '0;
      r_pcq_rd     <= '0;
      r_fb_wr      <= '0;
      r_fb_rd      <= '0;
      r_fb_cnt     <= '0;
      r_pc_out     <= 32'h0000_0000;
      r_inst       <= c_nop;
      r_inst_valid <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_out <= r_out + (w_req_hs ? CW'(1) : CW'(0)) - (imem_rsp_valid ? CW'(1) : CW'(0));

      if (redirect_valid) begin
        r_fpc        <= w_redirect_target;
        r_drop       <= r_out - (imem_rsp_valid ? CW'(1) : CW'(0));
        r_pcq_wr     <= '0;
        r_pcq_rd     <= '0;
        r_fb_wr      <= '0;
        r_fb_rd      <= '0;
        r_fb_cnt     <= '0;
        r_inst_valid <= 1'b0;
      end else begin
        if (w_req_hs) begin
          r_fpc    <= r_fpc + 32'd4;
          r_pcq_wr <= f_inc(r_pcq_wr);
        end
        if (imem_rsp_valid && (r_drop != '0)) begin
          r_drop <= r_drop - CW'(1);
        end
        if (w_rsp_live) begin
          r_pcq_rd <= f_inc(r_pcq_rd);
          r_fb_wr  <= f_inc(r_fb_wr);
        end
        if (w_fb_pop) begin
          r_fb_rd <= f_inc(r_fb_rd);
        end
        r_fb_cnt <= r_fb_cnt + (w_rsp_live ? CW'(1) : CW'(0)) - (w_fb_pop ? CW'(1) : CW'(0));

        if (w_load_ok) begin
          if (r_fb_cnt != '0) begin
            r_pc_out     <= r_fb_pc[r_fb_rd];
            r_inst       <= r_fb_inst[r_fb_rd];
            r_inst_valid <= 1'b1;
          end else begin
            r_inst_valid <= 1'b0;
          end
        end
      end
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (w_req_hs) begin
      r_pcq[r_pcq_wr] <= r_fpc;
    end
    if (w_rsp_live) begin
      r_fb_pc[r_fb_wr]   <= r_pcq[r_pcq_rd];
      r_fb_inst[r_fb_wr] <= imem_rsp_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ==================================================================
// tb_if_stage - directed self-checking bench for if_stage
// Revision 1.0
// ==================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_id;
  logic [31:0] pc_out;
  logic [31:0] inst_id;
  logic        inst_valid_id;

  int n_checks = 0;
  int n_errors = 0;
  int lat      = 1;
  int cyc      = 0;

  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_id       (stall_id),
    .pc_out         (pc_out),
    .inst_id        (inst_id),
    .inst_valid_id  (inst_valid_id)
  );

  // In-order memory: returns ~addr exactly lat edges after the request handshake.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      mq_addr.delete();
      mq_due.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
    end
    #1;
    if (reset && (mq_addr.size() > 0) && (mq_due[0] <= cyc + 1)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mq_addr[0];
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    reset          = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall_id       = 1'b0;
    lat            = 1;

    // Reset values, then streaming fetch with 1-cycle memory
    tick();
    tick();
    check("rst_req_valid", imem_req_valid, 32'd0);
    check("rst_req_addr",  imem_req_addr,  32'h0);
    check("rst_inst_valid", inst_valid_id, 32'd0);
    check("rst_inst_id",   inst_id,        32'h0000_0013);
    check("rst_pc_out",    pc_out,         32'h0);
    reset = 1'b1;
    tick();
    check("a_req_valid", imem_req_valid, 32'd1);
    check("a_req_addr0", imem_req_addr,  32'h0);
    tick();
    tick();
    check("a_inst_valid_early", inst_valid_id, 32'd0);
    tick();
    check("a_inst_valid", inst_valid_id, 32'd1);
    check("a_pc0",        pc_out,        32'h0);
    check("a_inst0",      inst_id,       ~32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("a_pc_step", pc_out, 32'(4 * i));
    end

    // Stall three cycles while pc_out = 0x10
    stall_id = 1'b1;
    tick();
    check("s_pc_hold1", pc_out, 32'h10);
    check("s_req_stop1", imem_req_valid, 32'd0);
    tick();
    check("s_pc_hold2", pc_out, 32'h10);
    check("s_req_stop2", imem_req_valid, 32'd0);
    tick();
    check("s_pc_hold3", pc_out, 32'h10);
    check("s_inst_hold", inst_id, ~32'h10);
    stall_id = 1'b0;
    tick();
    check("s_pc_14", pc_out, 32'h14);
    tick();
    check("s_pc_18", pc_out, 32'h18);
    tick();
    check("s_pc_1c", pc_out, 32'h1C);
    check("s_inst_1c", inst_id, ~32'h1C);

    // Memory not ready for five cycles after release
    imem_req_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_addr_hold", imem_req_addr, 32'h0);
      check("b_no_inst",   inst_valid_id, 32'd0);
    end
    imem_req_ready = 1'b1;
    tick();
    check("b_addr4", imem_req_addr, 32'h4);
    tick();
    tick();
    check("b_inst_valid", inst_valid_id, 32'd1);
    check("b_pc0",        pc_out,        32'h0);

    // Redirect with two requests outstanding, latency 3
    lat = 3;
    apply_reset();
    tick();
    tick();
    check("c_addr4", imem_req_addr, 32'h4);
    tick();
    check("c_credit_full", imem_req_valid, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("c_flush_inst", inst_valid_id, 32'd0);
    tick();
    check("c_req_valid", imem_req_valid, 32'd1);
    check("c_addr200",   imem_req_addr,  32'h200);
    repeat (5) tick();
    check("c_inst_valid", inst_valid_id, 32'd1);
    check("c_pc200",      pc_out,        32'h200);
    check("c_inst200",    inst_id,       ~32'h200);
    tick();
    check("c_pc204", pc_out, 32'h204);

    // Unaligned redirect concurrent with stall
    lat = 1;
    apply_reset();
    repeat (6) tick();
    check("d_pc8", pc_out, 32'h8);
    stall_id       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    check("d_flush_inst", inst_valid_id, 32'd0);
    check("d_addr100",    imem_req_addr, 32'h100);
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    check("d_no_old_rsp", inst_valid_id, 32'd0);
    tick();
    check("d_inst_valid", inst_valid_id, 32'd1);
    check("d_pc100",      pc_out,        32'h100);

    // Address wrap at top of memory, then reset mid-stream
    apply_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    check("e_addr_fff8", imem_req_addr, 32'hFFFF_FFF8);
    tick();
    check("e_addr_fffc", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    check("e_addr_wrap", imem_req_addr, 32'h0);
    tick();
    check("e_pc_fff8", pc_out, 32'hFFFF_FFF8);
    tick();
    check("e_pc_fffc", pc_out, 32'hFFFF_FFFC);
    tick();
    check("e_pc_wrap", pc_out, 32'h0);
    check("e_valid_wrap", inst_valid_id, 32'd1);
    reset = 1'b0;
    #1;
    check("e_rst_inst_valid", inst_valid_id, 32'd0);
    check("e_rst_req_valid",  imem_req_valid, 32'd0);
    check("e_rst_addr",       imem_req_addr,  32'h0);
    check("e_rst_inst",       inst_id,        32'h0000_0013);
    tick();
    reset = 1'b1;
    tick();
    check("e_refetch_addr", imem_req_addr, 32'h0);
    check("e_refetch_noinst", inst_valid_id, 32'd0);
    repeat (3) tick();
    check("e_refetch_pc", pc_out, 32'h0);
    check("e_refetch_valid", inst_valid_id, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
